// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed 7-segment scan driver with a valid/ready word input.
// Optional build macro SEG_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] i_bcd,
  input  logic [5:0]  i_dp,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [5:0]  o_seg_enb,
  output logic [6:0]  o_seg,
  output logic        o_seg_dp
);

  localparam int unsigned     PW      = $clog2(SCAN_DIV + 1);
  localparam logic [PW-1:0]   DIV_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, PEND} state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc;
  logic [2:0]    dig_idx, dig_idx_next;
  logic          scan_tick, frame_end;
  logic          capture, load;

  logic [23:0]   pend_bcd, act_bcd, show_bcd;
  logic [5:0]    pend_dp, act_dp, show_dp;
  logic [3:0]    digit;
  logic          digit_dp;
  logic [5:0]    enb_next;
  logic [6:0]    seg_next;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  assign scan_tick    = (presc == DIV_MAX);
  assign frame_end    = scan_tick && (dig_idx == 3'd5);
  assign dig_idx_next = (dig_idx == 3'd5) ? 3'd0 : dig_idx + 3'd1;
  assign o_ready      = (state == IDLE);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: if (i_valid) begin
        capture    = 1'b1;
        state_next = PEND;
      end
      PEND: if (frame_end) begin
        load       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The word being loaded at frame_end is already the one shown in the
  // digit-0 slot that the same tick registers.
  assign show_bcd = load ? pend_bcd : act_bcd;
  assign show_dp  = load ? pend_dp  : act_dp;

  always_comb begin
    digit    = 4'd0;
    digit_dp = 1'b0;
    enb_next = 6'h3F;
    for (int i = 0; i < 6; i++) begin
      if (dig_idx_next == 3'(i)) begin
        digit       = show_bcd[4*i +: 4];
        digit_dp    = show_dp[i];
        enb_next[i] = 1'b0;
      end
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic [5:0] blank;
  logic       zero_above;
  logic       blank_sel;

  // Digit 0 is excluded so a zero word still shows a single 0.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      zero_above = zero_above && (show_bcd[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
  end

  always_comb begin
    blank_sel = 1'b0;
    for (int i = 0; i < 6; i++)
      if (dig_idx_next == 3'(i)) blank_sel = blank[i];
  end

  assign seg_next = blank_sel ? 7'h7F : decode(digit);
`else
  assign seg_next = decode(digit);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      dig_idx   <= 3'd0;
      pend_bcd  <= '0;
      pend_dp   <= '0;
      act_bcd   <= '0;
      act_dp    <= '0;
      o_seg_enb <= 6'h3F;
      o_seg     <= 7'h7F;
      o_seg_dp  <= 1'b1;
    end else begin
      state <= state_next;
      presc <= scan_tick ? '0 : presc + 1'b1;
      if (capture) begin
        pend_bcd <= i_bcd;
        pend_dp  <= i_dp;
      end
      if (load) begin
        act_bcd <= pend_bcd;
        act_dp  <= pend_dp;
      end
      if (scan_tick) begin
        dig_idx   <= dig_idx_next;
        o_seg_enb <= enb_next;
        o_seg     <= (enb_next == 6'h3F) ? 7'h7F : seg_next;
        o_seg_dp  <= (enb_next == 6'h3F) ? 1'b1  : ~digit_dp;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: one instance at SCAN_DIV=4, one at SCAN_DIV=1.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [6:0] ZHI = 7'h7F;
`else
  localparam logic [6:0] ZHI = 7'h40;
`endif

  logic        rst, valid, ready, sdp;
  logic [23:0] bcd;
  logic [5:0]  dp, enb;
  logic [6:0]  seg;

  logic        rst1, valid1, ready1, sdp1;
  logic [23:0] bcd1;
  logic [5:0]  dp1, enb1;
  logic [6:0]  seg1;

  seg_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .i_bcd(bcd), .i_dp(dp), .i_valid(valid),
    .o_ready(ready), .o_seg_enb(enb), .o_seg(seg), .o_seg_dp(sdp)
  );

  seg_scan_ctrl #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .i_bcd(bcd1), .i_dp(dp1), .i_valid(valid1),
    .o_ready(ready1), .o_seg_enb(enb1), .o_seg(seg1), .o_seg_dp(sdp1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  logic [5:0] enb_t [5];
  logic [6:0] seg_t [5];
  logic       dp_t  [5];

  initial begin
    enb_t = '{6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    rst = 1'b1; valid = 1'b0; bcd = '0; dp = '0;
    rst1 = 1'b1; valid1 = 1'b0; bcd1 = '0; dp1 = '0;

    // Reset and blank period before the first scan_tick
    step(2);
    rst = 1'b0;
    check("rst_enb", enb, 6'h3F);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", sdp, 1'b1);
    check("rst_ready", ready, 1'b1);
    step(3);
    check("preticks_enb", enb, 6'h3F);
    check("preticks_ready", ready, 1'b1);
    step(1);
    check("tick1_seg", seg, ZHI);
    check("tick1_dp", sdp, 1'b1);
    step(20);
    check("d0_enb", enb, 6'h3E);
    check("d0_seg", seg, 7'h40);

    // Word accept and full frame display
    bcd = 24'h123456; dp = 6'b000100; valid = 1'b1;
    step(1);
    valid = 1'b0;
    check("accept_ready", ready, 1'b0);
    step(23);
    check("w1_d0_enb", enb, 6'h3E);
    check("w1_d0_seg", seg, 7'h02);
    check("w1_d0_dp", sdp, 1'b1);
    check("w1_ready", ready, 1'b1);
    seg_t = '{7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    dp_t  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step(4);
      check($sformatf("w1_d%0d_enb", i + 1), enb, enb_t[i]);
      check($sformatf("w1_d%0d_seg", i + 1), seg, seg_t[i]);
      check($sformatf("w1_d%0d_dp", i + 1), sdp, dp_t[i]);
    end

    // valid held across frame_end: one word per IDLE window; dash decode
    bcd = 24'h00000A; dp = '0; valid = 1'b1;
    step(1);
    check("hold_ready_lo", ready, 1'b0);
    step(3);
    check("fe_ready_hi", ready, 1'b1);
    check("dash_enb", enb, 6'h3E);
    check("dash_seg", seg, 7'h3F);
    check("dash_dp", sdp, 1'b1);
    bcd = 24'h987650;
    step(1);
    check("second_accept", ready, 1'b0);
    valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(4);
      check($sformatf("lz_d%0d_enb", i + 1), enb, enb_t[i]);
      check($sformatf("lz_d%0d_seg", i + 1), seg, ZHI);
    end
    step(4);
    check("w3_d0_enb", enb, 6'h3E);
    check("w3_d0_seg", seg, 7'h40);
    check("w3_ready", ready, 1'b1);
    step(4);
    check("w3_d1_seg", seg, 7'h12);

    // Reset mid-frame while PEND
    bcd = 24'h111111; dp = 6'h3F; valid = 1'b1;
    step(1);
    valid = 1'b0;
    check("pend_ready", ready, 1'b0);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_enb", enb, 6'h3F);
    check("mid_rst_seg", seg, 7'h7F);
    check("mid_rst_dp", sdp, 1'b1);
    check("mid_rst_ready", ready, 1'b1);
    step(4);
    check("post_rst_enb", enb, 6'h3D);
    check("post_rst_seg", seg, ZHI);
    step(20);
    check("post_rst_d0_enb", enb, 6'h3E);
    check("post_rst_d0_seg", seg, 7'h40);
    check("post_rst_d0_dp", sdp, 1'b1);
    check("post_rst_ready", ready, 1'b1);

    // SCAN_DIV = 1: rotate every cycle, load at the 5->0 wrap
    bcd1 = 24'h000007; dp1 = 6'b000001; valid1 = 1'b1; rst1 = 1'b0;
    step(1);
    valid1 = 1'b0;
    check("d1_enb_1", enb1, 6'h3D);
    check("d1_ready_lo", ready1, 1'b0);
    for (int i = 1; i < 5; i++) begin
      step(1);
      check($sformatf("d1_enb_%0d", i + 1), enb1, enb_t[i]);
    end
    check("d1_ready_pre_wrap", ready1, 1'b0);
    step(1);
    check("d1_wrap_enb", enb1, 6'h3E);
    check("d1_wrap_seg", seg1, 7'h78);
    check("d1_wrap_dp", sdp1, 1'b0);
    check("d1_wrap_ready", ready1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
